// File: rtl/ioctl_pkg.sv
// Shared types and constants for the hps_io ioctl upload path.
package ioctl_pkg;

  localparam int IOCTL_AW = 27;
  localparam int IOCTL_DW = 16;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_NVRAM = 8'd4;
  localparam logic [7:0] IDX_DIP   = 8'd254;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ioctl_upload_server.sv
// Serves HPS upload (save) reads for one ioctl index by fetching 16-bit words
// from a variable-latency core memory port and stalling hps_io until valid.
//
// state | meaning
// IDLE  | waiting for an accepted ioctl_rd strobe
// FETCH | mem_req held, waiting for mem_ack or the timeout
// DONE  | ioctl_din settled; ioctl_wait drops on the following cycle
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter logic [7:0]          INDEX   = IDX_NVRAM,
  parameter int                  AW      = 12,
  parameter int                  SIZE    = 8192,
  parameter int                  TIMEOUT = 255,
  parameter logic [IOCTL_DW-1:0] FILL    = 16'hFFFF
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [IOCTL_DW-1:0] ioctl_din,
  output logic                ioctl_wait,
  output logic                mem_req,
  output logic [AW-1:0]       mem_addr,
  input  logic [IOCTL_DW-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                upload_active,
  output logic                upload_done,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 2);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [IOCTL_DW-1:0] r_din;
  logic                r_mem_req;
  logic [AW-1:0]       r_mem_addr;
  logic                r_active;
  logic                r_done;
  logic                r_terr;

  logic w_sel;
  logic w_rd_go;
  logic w_in_range;
  logic w_cnt_end;
  logic w_fetch_start;
  logic w_oor_fill;
  logic w_ack_take;
  logic w_tmo_hit;
  logic w_wait;

  // Full-width compare so high address bits never alias into the memory.
  assign w_sel      = ioctl_upload & (ioctl_index == INDEX);
  assign w_rd_go    = ioctl_rd & w_sel;
  assign w_in_range = (ioctl_addr < IOCTL_AW'(SIZE));
  assign w_cnt_end  = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd_go) begin
          w_state_nxt = w_in_range ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (mem_ack || w_cnt_end) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // An ack on the timeout cycle still wins: w_tmo_hit excludes mem_ack.
  always_comb begin
    w_fetch_start = 1'b0;
    w_oor_fill    = 1'b0;
    w_ack_take    = 1'b0;
    w_tmo_hit     = 1'b0;
    w_wait        = (r_state != IDLE) | w_rd_go;
    case (r_state)
      IDLE: begin
        w_fetch_start = w_rd_go & w_in_range;
        w_oor_fill    = w_rd_go & ~w_in_range;
      end
      FETCH: begin
        w_ack_take = mem_ack;
        w_tmo_hit  = ~mem_ack & w_cnt_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_din      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_fetch_start) begin
        r_mem_addr <= ioctl_addr[AW:1];
        r_mem_req  <= 1'b1;
        r_cnt      <= '0;
      end else if (w_ack_take) begin
        r_din     <= mem_rdata;
        r_mem_req <= 1'b0;
      end else if (w_tmo_hit) begin
        r_din     <= FILL;
        r_mem_req <= 1'b0;
      end else if (r_state == FETCH) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_oor_fill) begin
        r_din <= FILL;
      end
    end
  end

  // Session tracking: the error flag is cleared when a new upload starts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_active <= w_sel;
      r_done   <= r_active & ~w_sel;
      if (w_tmo_hit) begin
        r_terr <= 1'b1;
      end else if (~r_active & w_sel) begin
        r_terr <= 1'b0;
      end
    end
  end

  assign ioctl_din     = r_din;
  assign ioctl_wait    = w_wait;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign upload_active = r_active;
  assign upload_done   = r_done;
  assign timeout_err   = r_terr;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server: vector table plus hand-written
// sequences for timeout, ack-at-timeout, session edges and reset mid-fetch.
module tb_ioctl_upload_server;

  localparam int AW = 12;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [26:0]   ioctl_addr;
  logic [15:0]   ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
  logic          mem_ack;
  logic          upload_active;
  logic          upload_done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  ioctl_upload_server dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .upload_active(upload_active),
    .upload_done  (upload_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]    idx;
    logic [26:0]   addr;
    int            dly;
    logic [15:0]   rdata;
    int            ewait;
    int            ereq;
    logic [AW-1:0] emaddr;
    logic [15:0]   edin;
    logic          eact;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One read transaction; dly < 0 means the memory never acks.
  task automatic do_read(input logic [26:0] a, input int dly, input logic [15:0] rd_data,
                         output int wait_cyc, output int req_cyc,
                         output logic [AW-1:0] maddr, output logic [15:0] din);
    int f;
    f = 0;
    wait_cyc = 0;
    req_cyc = 0;
    maddr = '0;
    @(negedge clk_sys);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    #1;
    if (ioctl_wait) wait_cyc++;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        req_cyc++;
        maddr = mem_addr;
        if (f == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rd_data;
        end
        f++;
      end
      if (ioctl_wait) wait_cyc++;
      else break;
    end
    mem_ack = 1'b0;
    din = ioctl_din;
  endtask

  initial begin
    int wc, rc, pulses;
    logic [AW-1:0] ma;
    logic [15:0] dn;

    vt[0] = '{8'd4, 27'h10,      0,  16'hA55A, 3, 1, 12'h008, 16'hA55A, 1'b1};
    vt[1] = '{8'd4, 27'h1FFE,    5,  16'h1234, 8, 6, 12'hFFF, 16'h1234, 1'b1};
    vt[2] = '{8'd4, 27'h2000,    0,  16'h0000, 2, 0, 12'h000, 16'hFFFF, 1'b1};
    vt[3] = '{8'd4, 27'h4000010, 0,  16'h0000, 2, 0, 12'h000, 16'hFFFF, 1'b1};
    vt[4] = '{8'd4, 27'h2,       2,  16'hBEEF, 5, 3, 12'h001, 16'hBEEF, 1'b1};
    vt[5] = '{8'd0, 27'h10,      0,  16'h1111, 0, 0, 12'h000, 16'hBEEF, 1'b0};
    vt[6] = '{8'd4, 27'h20,      1,  16'hC0DE, 4, 2, 12'h010, 16'hC0DE, 1'b1};

    reset_n = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index = 8'd0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    #1;
    check("rst_din", 32'(ioctl_din), 32'h0);
    check("rst_wait", 32'(ioctl_wait), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_maddr", 32'(mem_addr), 32'h0);
    check("rst_flags", {29'd0, upload_active, upload_done, timeout_err}, 32'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    ioctl_upload = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk_sys);
      ioctl_index = vt[i].idx;
      repeat (2) @(negedge clk_sys);
      check($sformatf("v%0d_active", i), 32'(upload_active), 32'(vt[i].eact));
      do_read(vt[i].addr, vt[i].dly, vt[i].rdata, wc, rc, ma, dn);
      check($sformatf("v%0d_wait", i), 32'(wc), 32'(vt[i].ewait));
      check($sformatf("v%0d_req", i), 32'(rc), 32'(vt[i].ereq));
      check($sformatf("v%0d_maddr", i), 32'(ma), 32'(vt[i].emaddr));
      check($sformatf("v%0d_din", i), 32'(dn), 32'(vt[i].edin));
      check($sformatf("v%0d_terr", i), 32'(timeout_err), 32'h0);
    end

    // Timeout: no ack ever; 256 FETCH cycles then fill and sticky error.
    do_read(27'h40, -1, 16'h0, wc, rc, ma, dn);
    check("tmo_wait", 32'(wc), 32'd258);
    check("tmo_req", 32'(rc), 32'd256);
    check("tmo_maddr", 32'(ma), 32'h020);
    check("tmo_din", 32'(dn), 32'hFFFF);
    check("tmo_err", 32'(timeout_err), 32'h1);

    // End of session: exactly one upload_done pulse, error stays sticky.
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      if (upload_done) pulses++;
    end
    check("done_pulses", 32'(pulses), 32'd1);
    check("err_sticky", 32'(timeout_err), 32'h1);
    check("inactive", 32'(upload_active), 32'h0);

    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("err_cleared", 32'(timeout_err), 32'h0);
    check("reactive", 32'(upload_active), 32'h1);
    check("no_done_on_rise", 32'(upload_done), 32'h0);

    // Ack on the final counter cycle wins over the timeout.
    do_read(27'h80, 255, 16'h5AA5, wc, rc, ma, dn);
    check("edge_wait", 32'(wc), 32'd258);
    check("edge_req", 32'(rc), 32'd256);
    check("edge_din", 32'(dn), 32'h5AA5);
    check("edge_err", 32'(timeout_err), 32'h0);

    // Reset in the middle of a fetch.
    @(negedge clk_sys);
    ioctl_rd = 1'b1;
    ioctl_addr = 27'h10;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    #1;
    check("mid_req", 32'(mem_req), 32'h1);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_wait", 32'(ioctl_wait), 32'h0);
    check("mid_rst_din", 32'(ioctl_din), 32'h0);
    check("mid_rst_act", 32'(upload_active), 32'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    do_read(27'h10, 0, 16'h3C3C, wc, rc, ma, dn);
    check("post_rst_wait", 32'(wc), 32'd3);
    check("post_rst_din", 32'(dn), 32'h3C3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
